// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined two-level carry-lookahead adder/subtractor, optional saturation via CLA_PIPE_SAT_EN
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             sat
);

    localparam int NG = WIDTH / GROUP;

    // First-level lookahead results: per-group G/P plus carry-select local sums.
    typedef struct packed {
        logic [NG-1:0]    g;
        logic [NG-1:0]    p;
        logic [WIDTH-1:0] sum0;
        logic [WIDTH-1:0] sum1;
        logic             a_msb;
        logic             b_msb;
        logic             cin;
    } mid_t;

    typedef struct packed {
        logic             sat;
        logic             zero;
        logic             ovf;
        logic             c_out;
        logic [WIDTH-1:0] s;
    } res_t;

    function automatic mid_t mid_f(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                                   input logic sub_v, input logic cin_v);
        mid_t             m;
        logic [WIDTH-1:0] be;
        logic [GROUP:0]   t0;
        logic [GROUP-1:0] t1;
        be      = sub_v ? ~b_v : b_v;
        m       = '0;
        m.cin   = sub_v ? 1'b1 : cin_v;
        m.a_msb = a_v[WIDTH-1];
        m.b_msb = be[WIDTH-1];
        for (int j = 0; j < NG; j++) begin
            t0 = {1'b0, a_v[j*GROUP +: GROUP]} + {1'b0, be[j*GROUP +: GROUP]};
            t1 = t0[GROUP-1:0] + {{(GROUP-1){1'b0}}, 1'b1};
            m.sum0[j*GROUP +: GROUP] = t0[GROUP-1:0];
            m.sum1[j*GROUP +: GROUP] = t1;
            m.g[j] = t0[GROUP];
            m.p[j] = &(a_v[j*GROUP +: GROUP] ^ be[j*GROUP +: GROUP]);
        end
        return m;
    endfunction

    // Second-level lookahead: ripple group carries across G/P, then select each group's sum.
    function automatic res_t res_f(input mid_t m);
        res_t r;
        logic c;
        r = '0;
        c = m.cin;
        for (int j = 0; j < NG; j++) begin
            r.s[j*GROUP +: GROUP] = c ? m.sum1[j*GROUP +: GROUP] : m.sum0[j*GROUP +: GROUP];
            c = m.g[j] | (m.p[j] & c);
        end
        r.c_out = c;
        r.ovf   = (m.a_msb == m.b_msb) && (r.s[WIDTH-1] != m.a_msb);
`ifdef CLA_PIPE_SAT_EN
        if (r.ovf) begin
            r.s   = m.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            r.sat = 1'b1;
        end
`endif
        r.zero = (r.s == '0);
        return r;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] acc;
    res_t              res_q;

    // Backward ready chain: a stage moves on when it is full and the next slot frees up.
    always_comb begin
        logic go;
        go  = out_ready;
        adv = '0;
        acc = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = v_q[k] && go;
            go     = !v_q[k] || go;
        end
        in_ready = go;
        acc[0]   = in_valid && go;
        for (int k = 1; k < STAGES; k++) begin
            acc[k] = adv[k-1];
        end
    end

    // Stage occupancy: filled on accept, emptied on advance, held when both or neither.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (acc[k]) begin
                    v_q[k] <= 1'b1;
                end else if (adv[k]) begin
                    v_q[k] <= 1'b0;
                end
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_one
            // Single stage: both lookahead levels in front of the only register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q <= '0;
                end else if (acc[0]) begin
                    res_q <= res_f(mid_f(a, b, sub, c_in));
                end
            end
        end else begin : g_multi
            mid_t mid_q [STAGES-1];

            // First stage captures group G/P and carry-select sums; middle stages only delay them.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < STAGES - 1; k++) begin
                        mid_q[k] <= '0;
                    end
                end else begin
                    if (acc[0]) begin
                        mid_q[0] <= mid_f(a, b, sub, c_in);
                    end
                    for (int k = 1; k < STAGES - 1; k++) begin
                        if (acc[k]) begin
                            mid_q[k] <= mid_q[k-1];
                        end
                    end
                end
            end

            // Last stage resolves group carries and registers result and flags.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q <= '0;
                end else if (acc[STAGES-1]) begin
                    res_q <= res_f(mid_q[STAGES-2]);
                end
            end
        end
    endgenerate

    assign out_valid = v_q[STAGES-1];
    assign s         = res_q.s;
    assign c_out     = res_q.c_out;
    assign ovf       = res_q.ovf;
    assign zero      = res_q.zero;
    assign sat       = res_q.sat;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - randomized self-checking bench for cla_pipe_addsub
module tb_cla_pipe_addsub;

    localparam int W      = 32;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         c_out, ovf, zero, sat;

    int n_checks = 0;
    int n_errors = 0;
    int n_in = 0;
    int n_out = 0;

    logic [W+3:0] exp_q [$];
    logic [W+3:0] held;
    logic         hold_v = 1'b0;
    logic [W+3:0] dut_word;

    assign dut_word = {sat, zero, ovf, c_out, s};

    cla_pipe_addsub #(.WIDTH(W), .GROUP(4), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .ovf(ovf), .zero(zero), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on wide values.
    function automatic logic [W+3:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic sv, input logic cv);
        longint       sa, sb, r;
        logic [W-1:0] res;
        logic         c, o, z, st;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (sv) begin
            r = sa - sb;
            c = (av >= bv);
        end else begin
            r = sa + sb + longint'(cv);
            c = ((longint'(av) + longint'(bv) + longint'(cv)) >= 64'sd4294967296);
        end
        o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        res = r[W-1:0];
        st  = 1'b0;
`ifdef CLA_PIPE_SAT_EN
        if (o) begin
            res = av[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            st  = 1'b1;
        end
`endif
        z = (res == '0);
        return {st, z, o, c, res};
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake, watch stalls.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
                check_eq("stall_stable", {28'd0, dut_word}, {28'd0, held});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 64'd1, 64'd0);
                end else begin
                    check_eq("result", {28'd0, dut_word}, {28'd0, exp_q.pop_front()});
                end
                n_out++;
            end
            hold_v = out_valid && !out_ready;
            held   = dut_word;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub, c_in));
                n_in++;
            end
        end
    end

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input logic cv);
        a = av; b = bv; sub = sv; c_in = cv;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input logic cv);
        logic acc;
        int   n;
        drive(av, bv, sv, cv);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // One beat into an idle pipe with out_ready high; counts edges until out_valid.
    task automatic lat_beat(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input logic cv);
        int lat;
        drive(av, bv, sv, cv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("latency", 64'(lat), 64'(STAGES));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int accepts;
        int in5, out5;
        logic acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_word", {28'd0, dut_word}, 64'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        out_ready = 1'b1;
        lat_beat(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drain();
        lat_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drain();
        send(32'd5, 32'd7, 1'b1, 1'b0);
        send(32'd7, 32'd5, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        drain();

        // Back-pressure: pipe fills after STAGES accepts, then drains in order
        out_ready = 1'b0;
        accepts = 0;
        drive(32'h10, 32'h1, 1'b0, 1'b0);
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                drive(32'h10 + 32'(accepts), 32'h1, 1'b0, 1'b0);
            end
        end
        check_eq("bp_accepts", 64'(accepts), 64'(STAGES));
        @(negedge clk);
        check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        while (accepts < 4) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                drive(32'h10 + 32'(accepts), 32'h1, 1'b0, 1'b0);
            end
        end
        in_valid = 1'b0;
        drain();

        // Random stream with random back-pressure
        in5 = n_in;
        out5 = n_out;
        accepts = 0;
        acc = 1'b1;
        while (accepts < 100) begin
            out_ready = ($urandom_range(3) != 0);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(4) != 0);
                case ($urandom_range(3))
                    0: drive(32'h7FFF_FFFF, $urandom(), 1'($urandom()), 1'($urandom()));
                    1: drive(32'h8000_0000, $urandom(), 1'($urandom()), 1'($urandom()));
                    default: drive($urandom(), $urandom(), 1'($urandom()), 1'($urandom()));
                endcase
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) accepts++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        check_eq("rand_count", 64'(n_out - out5), 64'(n_in - in5));

        // Asynchronous reset with beats in flight
        out_ready = 1'b0;
        send(32'd3, 32'd4, 1'b0, 1'b0);
        send(32'd9, 32'd1, 1'b0, 1'b0);
        check_eq("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("arst_word", {28'd0, dut_word}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        lat_beat(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
